teclado_ps2: RTL and testbench
==============================

TECLADO_PS2 -- requirements
Module: teclado_ps2

Interface
REQ-001 The block SHALL run on one clock, and reset SHALL be synchronous and active-low.
REQ-002 Port clock, input, 1 bit: 25 MHz system clock, the same clock that drives the VGA timing.
REQ-003 Port reset, input, 1 bit: synchronous reset, active-low (0 = reset).
REQ-004 Port ps2_clk, input, 1 bit: raw PS/2 keyboard clock, asynchronous to clock.
REQ-005 Port ps2_data, input, 1 bit: raw PS/2 keyboard data, asynchronous to clock.
REQ-006 Port tecla, output, 6 bits, registered: held piano key.
  - 0 = none.
  - 1..16 = upper row, key n.
  - 17..32 = lower row, key n-16.
REQ-007 Port nota_nueva, output, 1 bit, registered: 1-cycle pulse when tecla takes a new nonzero value.
REQ-008 Port error_trama, output, 1 bit, registered: 1-cycle pulse on a dropped frame (parity, stop or timeout).

Function
REQ-009 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer before any use.
REQ-010 A PS/2 falling edge SHALL be detected as a synchronized ps2_clk 1->0 transition, one-cycle strobe.
REQ-011 Receiver FSM states SHALL be REPOSO, DATOS, PARIDAD, PARADA; all transitions occur only on a falling-edge strobe or on timeout.
REQ-012 REPOSO -> DATOS on a strobe with data=0 (start bit); a strobe with data=1 SHALL be ignored.
REQ-013 DATOS SHALL shift 8 bits LSB first; after the 8th bit -> PARIDAD.
REQ-014 PARIDAD SHALL capture the parity bit -> PARADA.
REQ-015 PARADA SHALL return to REPOSO. The byte is accepted iff stop=1 and the 9 bits have odd parity; otherwise error_trama pulses.
REQ-016 Outside REPOSO, 25000 cycles (1 ms) without a strobe SHALL abort to REPOSO and pulse error_trama.
  - The timeout counter is 15 bits and restarts on every strobe.
REQ-017 An accepted byte SHALL be decoded the cycle after the PARADA strobe; tecla and nota_nueva update on the following cycle (2-cycle latency from the stop-bit strobe).
REQ-018 Decoding of an accepted byte:
  - 0xF0 sets the break flag.
  - 0xE0 sets the extended flag.
  - Any other byte is a key code; both flags clear after it is consumed.
REQ-019 The key code map SHALL be, in order:
  - Upper row 1..16 = Q W E R T Y U I O P 1 2 3 4 5 6 (0x15 1D 24 2D 2C 35 3C 43 44 4D 16 1E 26 25 2E 36).
  - Lower row 17..32 = A S D F G H J K L Z X C V B N M (0x1C 1B 23 2B 34 33 3B 42 4B 1A 22 21 2A 32 31 3A).
REQ-020 For a make code (break flag 0, extended flag 0) that maps to key k:
  - If k differs from tecla, tecla <= k and nota_nueva pulses.
  - If k equals tecla (typematic repeat), there is no change and no pulse.
REQ-021 For a break code that maps to the held key, tecla <= 0; a break of any other key SHALL be ignored.
REQ-022 Unmapped codes and any code with the extended flag set SHALL leave tecla unchanged.
REQ-023 A dropped frame SHALL NOT alter the break or extended flags.
REQ-024 A new make while a key is held SHALL replace tecla directly, with no intermediate 0.

Reset
REQ-025 While reset=0, the following SHALL be forced: FSM=REPOSO, shift register=0, bit counter=0, timeout counter=0, both flags=0, tecla=0, nota_nueva=0, error_trama=0.
REQ-026 Reset asserted mid-frame SHALL discard the partial frame; reception resumes at the next start bit after reset=1.
REQ-027 Synchronizer flops SHALL reset to 1 (PS/2 idle level), so no false edge occurs at reset release.

Structure
REQ-028 A shared package teclado_pkg SHALL hold:
  - Timeout constant 25000.
  - Prefix constants 0xF0 and 0xE0.
  - The 32-entry scancode-to-tecla map function.
  - The FSM state encoding.
REQ-029 Frame reception (REQ-009..016) SHALL be the sub-module ps2_rx, outputting byte[7:0], byte_ok (1-cycle pulse) and error_trama; teclado_ps2 holds decode and hold logic.

Verification
REQ-030 Make 0x15, bit period 80 us -> tecla=1, one nota_nueva pulse 2 cycles after the stop-bit strobe.
REQ-031 Make 0x1C, then F0 1C -> tecla=17, then tecla=0; nota_nueva pulses exactly once.
REQ-032 Make 0x15, repeat 0x15 x3, then make 0x3A -> tecla 1 (single pulse), unchanged, then 32 with a second pulse.
REQ-033 Frame 0x15 with wrong parity, and a separate frame with stop=0 -> error_trama pulses each time, tecla stays 0.
REQ-034 Start bit plus 4 data bits then silence for 2 ms -> error_trama at 25000 cycles; a following valid 0x1D gives tecla=2.
REQ-035 reset=0 mid-frame of 0x1D, released, then E0 15, then 0x24 -> tecla stays 0 through E0 15, then tecla=3.

Source files
------------

// File: rtl/teclado_pkg.sv
// Shared constants, receiver state encoding and the PS/2 scancode to piano-key map.
package teclado_pkg;

  localparam logic [14:0] TIMEOUT_CICLOS = 15'd25000;
  localparam logic [7:0]  PREF_BREAK     = 8'hF0;
  localparam logic [7:0]  PREF_EXT       = 8'hE0;

  typedef enum logic [1:0] {
    REPOSO  = 2'd0,
    DATOS   = 2'd1,
    PARIDAD = 2'd2,
    PARADA  = 2'd3
  } rx_estado_t;

  // Upper row (QWERTYUIOP123456) is 1..16, lower row (ASDFGHJKLZXCVBNM) is 17..32.
  function automatic logic [5:0] codigo_a_tecla(input logic [7:0] codigo);
    logic [5:0] t;
    t = 6'd0;
    case (codigo)
      8'h15: t = 6'd1;
      8'h1D: t = 6'd2;
      8'h24: t = 6'd3;
      8'h2D: t = 6'd4;
      8'h2C: t = 6'd5;
      8'h35: t = 6'd6;
      8'h3C: t = 6'd7;
      8'h43: t = 6'd8;
      8'h44: t = 6'd9;
      8'h4D: t = 6'd10;
      8'h16: t = 6'd11;
      8'h1E: t = 6'd12;
      8'h26: t = 6'd13;
      8'h25: t = 6'd14;
      8'h2E: t = 6'd15;
      8'h36: t = 6'd16;
      8'h1C: t = 6'd17;
      8'h1B: t = 6'd18;
      8'h23: t = 6'd19;
      8'h2B: t = 6'd20;
      8'h34: t = 6'd21;
      8'h33: t = 6'd22;
      8'h3B: t = 6'd23;
      8'h42: t = 6'd24;
      8'h4B: t = 6'd25;
      8'h1A: t = 6'd26;
      8'h22: t = 6'd27;
      8'h21: t = 6'd28;
      8'h2A: t = 6'd29;
      8'h32: t = 6'd30;
      8'h31: t = 6'd31;
      8'h3A: t = 6'd32;
      default: t = 6'd0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronises the raw lines, samples on falling edges and
// checks start/parity/stop; byte_ok and error_trama are one-cycle pulses.
module ps2_rx
  import teclado_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_ok,
  output logic       error_trama
);

  logic clk_s1_q, clk_s2_q, clk_s3_q, dat_s1_q, dat_s2_q;
  logic falla;

  rx_estado_t  estado_q, estado_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bits_q, bits_d;
  logic [14:0] tmo_q, tmo_d;
  logic        paridad_q, paridad_d;
  logic        byte_ok_q, byte_ok_d;
  logic        error_q, error_d;

  // Idle level of both PS/2 lines is 1, so reset to 1 avoids a false edge on release.
  always_ff @(posedge clock) begin
    if (!reset) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      clk_s3_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= ps2_clk;
      clk_s2_q <= clk_s1_q;
      clk_s3_q <= clk_s2_q;
      dat_s1_q <= ps2_data;
      dat_s2_q <= dat_s1_q;
    end
  end

  assign falla = clk_s3_q & ~clk_s2_q;

  always_comb begin
    estado_d  = estado_q;
    shift_d   = shift_q;
    bits_d    = bits_q;
    tmo_d     = tmo_q;
    paridad_d = paridad_q;
    byte_ok_d = 1'b0;
    error_d   = 1'b0;
    if (falla) begin
      tmo_d = '0;
      case (estado_q)
        REPOSO: begin
          if (!dat_s2_q) begin
            estado_d = DATOS;
            bits_d   = '0;
            shift_d  = '0;
          end
        end
        DATOS: begin
          shift_d = {dat_s2_q, shift_q[7:1]};
          bits_d  = bits_q + 3'd1;
          if (bits_q == 3'd7) estado_d = PARIDAD;
        end
        PARIDAD: begin
          paridad_d = dat_s2_q;
          estado_d  = PARADA;
        end
        PARADA: begin
          estado_d = REPOSO;
          if (dat_s2_q && (^{paridad_q, shift_q})) byte_ok_d = 1'b1;
          else                                     error_d   = 1'b1;
        end
        default: estado_d = REPOSO;
      endcase
    end else if (estado_q != REPOSO) begin
      if (tmo_q == TIMEOUT_CICLOS - 15'd1) begin
        estado_d = REPOSO;
        tmo_d    = '0;
        error_d  = 1'b1;
      end else begin
        tmo_d = tmo_q + 15'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado_q  <= REPOSO;
      shift_q   <= '0;
      bits_q    <= '0;
      tmo_q     <= '0;
      paridad_q <= 1'b0;
      byte_ok_q <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      shift_q   <= shift_d;
      bits_q    <= bits_d;
      tmo_q     <= tmo_d;
      paridad_q <= paridad_d;
      byte_ok_q <= byte_ok_d;
      error_q   <= error_d;
    end
  end

  assign rx_byte     = shift_q;
  assign byte_ok     = byte_ok_q;
  assign error_trama = error_q;

endmodule

// File: rtl/teclado_ps2.sv
// PS/2 keyboard to piano key: tracks break/extended prefixes and holds the last
// pressed key; tecla updates two cycles after the stop-bit edge.
module teclado_ps2
  import teclado_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [5:0] tecla,
  output logic       nota_nueva,
  output logic       error_trama
);

  logic [7:0] rx_byte;
  logic       byte_ok;
  logic [5:0] k;

  logic       brk_q, brk_d;
  logic       ext_q, ext_d;
  logic [5:0] tecla_q, tecla_d;
  logic       nota_q, nota_d;

  ps2_rx u_rx (
    .clock       (clock),
    .reset       (reset),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .rx_byte     (rx_byte),
    .byte_ok     (byte_ok),
    .error_trama (error_trama)
  );

  always_comb begin
    k       = codigo_a_tecla(rx_byte);
    brk_d   = brk_q;
    ext_d   = ext_q;
    tecla_d = tecla_q;
    nota_d  = 1'b0;
    if (byte_ok) begin
      if (rx_byte == PREF_BREAK) begin
        brk_d = 1'b1;
      end else if (rx_byte == PREF_EXT) begin
        ext_d = 1'b1;
      end else begin
        brk_d = 1'b0;
        ext_d = 1'b0;
        // Extended keys never touch the piano; a break only releases the held key.
        if (!ext_q && k != 6'd0) begin
          if (!brk_q) begin
            if (k != tecla_q) begin
              tecla_d = k;
              nota_d  = 1'b1;
            end
          end else if (k == tecla_q) begin
            tecla_d = 6'd0;
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      brk_q   <= 1'b0;
      ext_q   <= 1'b0;
      tecla_q <= 6'd0;
      nota_q  <= 1'b0;
    end else begin
      brk_q   <= brk_d;
      ext_q   <= ext_d;
      tecla_q <= tecla_d;
      nota_q  <= nota_d;
    end
  end

  assign tecla      = tecla_q;
  assign nota_nueva = nota_q;

endmodule

// File: tb/tb_teclado_ps2.sv
// Bench for teclado_ps2: directed vector table, hand sequences for latency,
// timeout and reset corner cases, then random frames against a key-state model.
`timescale 1ns/1ps
module tb_teclado_ps2;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [5:0] tecla;
  logic       nota_nueva;
  logic       error_trama;

  teclado_ps2 dut (
    .clock       (clock),
    .reset       (reset),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .tecla       (tecla),
    .nota_nueva  (nota_nueva),
    .error_trama (error_trama)
  );

  always #20 clock = ~clock;

  int cyc = 0;
  int nota_cnt = 0, err_cnt = 0;
  int last_nota_cyc = 0, last_err_cyc = 0, last_fall_cyc = 0;
  int n_chk = 0, n_fail = 0;
  int exp_nota = 0, exp_err = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (nota_nueva) begin nota_cnt++; last_nota_cyc = cyc; end
    if (error_trama) begin err_cnt++; last_err_cyc = cyc; end
  end

  typedef struct {
    logic [7:0] sc;
    bit         bad_par;
    bit         bad_stop;
    int         exp_tecla;
    int         nota_inc;
    int         err_inc;
  } vec_t;

  vec_t tab[$];

  logic [7:0] mapa[32] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43,
                           8'h44, 8'h4D, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
                           8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B, 8'h42,
                           8'h4B, 8'h1A, 8'h22, 8'h21, 8'h2A, 8'h32, 8'h31, 8'h3A};

  int m_tecla = 0;
  bit m_brk = 0, m_ext = 0;

  function automatic int map_of(input logic [7:0] b);
    for (int i = 0; i < 32; i++) if (mapa[i] == b) return i + 1;
    return 0;
  endfunction

  function automatic logic [10:0] frame(input logic [7:0] b, input bit bp, input bit bs);
    logic par;
    par = ~(^b);
    if (bp) par = ~par;
    return {(bs ? 1'b0 : 1'b1), par, b, 1'b0};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n, input int half);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      wait_cyc(half);
      ps2_clk = 1'b0;
      last_fall_cyc = cyc;
      wait_cyc(half);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bp, input bit bs, input int half);
    send_bits(frame(b, bp, bs), 11, half);
    wait_cyc(40);
  endtask

  task automatic check_state(input string tag, input int exp_t);
    chk({tag, "_tecla"}, int'(tecla), exp_t);
    chk({tag, "_nota"}, nota_cnt, exp_nota);
    chk({tag, "_err"}, err_cnt, exp_err);
  endtask

  // Key-state model built from the prefix/make/break rules.
  task automatic model_send(input logic [7:0] b, input bit bp, input bit bs);
    int k;
    if (bp || bs) begin
      exp_err++;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else begin
      k = map_of(b);
      if (!m_ext && k != 0) begin
        if (!m_brk && k != m_tecla) begin m_tecla = k; exp_nota++; end
        else if (m_brk && k == m_tecla) m_tecla = 0;
      end
      m_brk = 0;
      m_ext = 0;
    end
    send_frame(b, bp, bs, 8);
    check_state("rnd", m_tecla);
  endtask

  initial begin
    #(98000 * 40);
    $display("FAIL watchdog: simulation exceeded cycle budget at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int stop_cyc, e0, w, d, r;
    logic [7:0] b;

    tab.push_back('{8'h1C, 0, 0, 17, 1, 0});
    tab.push_back('{8'hF0, 0, 0, 17, 0, 0});
    tab.push_back('{8'h1C, 0, 0,  0, 0, 0});
    tab.push_back('{8'h15, 0, 0,  1, 1, 0});
    tab.push_back('{8'h15, 0, 0,  1, 0, 0});
    tab.push_back('{8'h15, 0, 0,  1, 0, 0});
    tab.push_back('{8'h15, 0, 0,  1, 0, 0});
    tab.push_back('{8'h3A, 0, 0, 32, 1, 0});
    tab.push_back('{8'hF0, 0, 0, 32, 0, 0});
    tab.push_back('{8'h15, 0, 0, 32, 0, 0});
    tab.push_back('{8'hF0, 0, 0, 32, 0, 0});
    tab.push_back('{8'h3A, 0, 0,  0, 0, 0});
    tab.push_back('{8'h15, 1, 0,  0, 0, 1});
    tab.push_back('{8'h15, 0, 1,  0, 0, 1});
    tab.push_back('{8'hF0, 1, 0,  0, 0, 1});
    tab.push_back('{8'h15, 0, 0,  1, 1, 0});
    tab.push_back('{8'hF0, 0, 0,  1, 0, 0});
    tab.push_back('{8'h1C, 0, 1,  1, 0, 1});
    tab.push_back('{8'h15, 0, 0,  0, 0, 0});
    tab.push_back('{8'hE0, 0, 0,  0, 0, 0});
    tab.push_back('{8'h1C, 0, 0,  0, 0, 0});
    tab.push_back('{8'h1C, 0, 0, 17, 1, 0});
    tab.push_back('{8'h77, 0, 0, 17, 0, 0});
    tab.push_back('{8'hF0, 0, 0, 17, 0, 0});
    tab.push_back('{8'h77, 0, 0, 17, 0, 0});
    tab.push_back('{8'h1C, 0, 0, 17, 0, 0});

    // Reset state, and no spurious edge when reset releases.
    wait_cyc(5);
    check_state("reset", 0);
    reset = 1'b1;
    wait_cyc(10);
    check_state("post_reset", 0);

    // Make 0x15 at an 80 us bit period; check decode latency.
    send_bits(frame(8'h15, 0, 0), 11, 1000);
    stop_cyc = last_fall_cyc;
    wait_cyc(40);
    exp_nota++;
    check_state("slow_make", 1);
    chk("nota_latency", last_nota_cyc - stop_cyc, 4);

    for (int i = 0; i < tab.size(); i++) begin
      send_frame(tab[i].sc, tab[i].bad_par, tab[i].bad_stop, 10);
      exp_nota += tab[i].nota_inc;
      exp_err  += tab[i].err_inc;
      check_state($sformatf("vec%0d", i), tab[i].exp_tecla);
    end

    // Start bit + 4 data bits, then silence until the timeout fires.
    send_bits(frame(8'h1D, 0, 0), 5, 10);
    stop_cyc = last_fall_cyc;
    e0 = err_cnt;
    w = 0;
    while (err_cnt == e0 && w < 30000) begin wait_cyc(1); w++; end
    exp_err++;
    chk("tmo_fired", err_cnt, exp_err);
    d = last_err_cyc - stop_cyc;
    chk("tmo_delay_in_window", int'(d >= 24999 && d <= 25006), 1);
    wait_cyc(200);
    chk("tmo_single_pulse", err_cnt, exp_err);
    send_frame(8'h1D, 0, 0, 10);
    exp_nota++;
    check_state("after_tmo", 2);

    // Reset mid-frame discards the partial frame and clears held state.
    send_bits(frame(8'h1D, 0, 0), 5, 10);
    reset = 1'b0;
    wait_cyc(5);
    chk("midreset_tecla", int'(tecla), 0);
    reset = 1'b1;
    wait_cyc(20);
    send_frame(8'hE0, 0, 0, 10);
    check_state("rst_e0", 0);
    send_frame(8'h15, 0, 0, 10);
    check_state("rst_e0_15", 0);
    send_frame(8'h24, 0, 0, 10);
    exp_nota++;
    check_state("rst_24", 3);

    m_tecla = 3;
    m_brk = 0;
    m_ext = 0;
    for (int it = 0; it < 60; it++) begin
      r = $urandom_range(0, 9);
      if (r <= 4) begin
        model_send(mapa[$urandom_range(0, 31)], 0, 0);
      end else if (r == 5) begin
        model_send(8'hF0, 0, 0);
        if (m_tecla != 0 && $urandom_range(0, 1) == 1) model_send(mapa[m_tecla - 1], 0, 0);
        else model_send(mapa[$urandom_range(0, 31)], 0, 0);
      end else if (r == 6) begin
        model_send(8'hE0, 0, 0);
      end else if (r == 7) begin
        do b = 8'($urandom_range(0, 255));
        while (map_of(b) != 0 || b == 8'hF0 || b == 8'hE0);
        model_send(b, 0, 0);
      end else if (r == 8) begin
        model_send(8'($urandom_range(0, 255)), 1, 0);
      end else begin
        model_send(8'($urandom_range(0, 255)), 0, 1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
